// File: rtl/abro_ctrl_pkg.sv
// Shared types and constants for the ABRO controller.
package abro_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StRestart
  } ctrl_state_e;

  // One-hot State encodings reported by the ABRO machine.
  localparam logic [3:0] ABRO_ST_IDLE = 4'b0001;
  localparam logic [3:0] ABRO_ST_A    = 4'b0010;
  localparam logic [3:0] ABRO_ST_O    = 4'b0100;

  localparam int unsigned CntW = 8;

  function automatic logic is_onehot4(logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/abro_ctrl_rr_arbiter.sv
// Round-robin select: first set request at or after ptr_i, wrapping around.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      j = 32'(ptr_i) + i;
      if (j >= NumReq) j = j - NumReq;
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/abro_ctrl.sv
// Shares one ABRO state machine among NumReq requesters with round-robin grant.
// Optional state checking is enabled by defining ABRO_CTRL_STATE_CHECK_EN.
module abro_ctrl
  import abro_ctrl_pkg::*;
#(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned Timeout = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] ev_a_i,
  input  logic [NumReq-1:0] ev_b_i,
  output logic [NumReq-1:0] grant_o,
  output logic [NumReq-1:0] done_o,
  output logic [NumReq-1:0] abort_o,
  output logic              abro_a_o,
  output logic              abro_b_o,
  output logic              abro_rst_n_o,
  input  logic              abro_o_i,
  input  logic [3:0]        abro_state_i,
  output logic              err_o
);

  localparam int unsigned     IdxW    = $clog2(NumReq);
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

  ctrl_state_e       state_q, state_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [NumReq-1:0] done_q, done_d;
  logic [NumReq-1:0] abort_q, abort_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              abro_a_q, abro_a_d;
  logic              abro_b_q, abro_b_d;
  logic              abro_rst_n_q, abro_rst_n_d;

  logic [NumReq-1:0] sel;
  logic [IdxW-1:0]   sel_idx;

  rr_arbiter #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_rr_arbiter (
    .req_i(req_i),
    .ptr_i(rr_ptr_q),
    .gnt_o(sel)
  );

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (sel[i]) sel_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    abort_d  = '0;
    abro_a_d = 1'b0;
    abro_b_d = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (|req_i) begin
          grant_d = sel;
          owner_d = sel_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // Priority: O beats timeout beats early release.
        if (abro_o_i) begin
          done_d  = grant_q;
          state_d = StRestart;
        end else if (cnt_q == CntLast) begin
          abort_d = grant_q;
          state_d = StRestart;
        end else if (!req_i[owner_q]) begin
          state_d = StRestart;
        end
        if (state_d == StBusy) begin
          abro_a_d = ev_a_i[owner_q];
          abro_b_d = ev_b_i[owner_q];
        end else begin
          grant_d = '0;
        end
      end
      StRestart: begin
        rr_ptr_d = (owner_q == IdxLast) ? '0 : owner_q + IdxW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    abro_rst_n_d = (state_d != StRestart);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      done_q       <= '0;
      abort_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      abro_a_q     <= 1'b0;
      abro_b_q     <= 1'b0;
      abro_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      abro_a_q     <= abro_a_d;
      abro_b_q     <= abro_b_d;
      abro_rst_n_q <= abro_rst_n_d;
    end
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign abort_o      = abort_q;
  assign abro_a_o     = abro_a_q;
  assign abro_b_o     = abro_b_q;
  assign abro_rst_n_o = abro_rst_n_q;

`ifdef ABRO_CTRL_STATE_CHECK_EN
  logic err_q, err_d;
  logic restart_seen_q;

  always_comb begin
    err_d = err_q;
    if (abro_rst_n_q && !is_onehot4(abro_state_i)) err_d = 1'b1;
    // The machine must be back in its idle state right after our restart pulse.
    if (state_q == StIdle && restart_seen_q && abro_state_i != ABRO_ST_IDLE) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q          <= 1'b0;
      restart_seen_q <= 1'b0;
    end else begin
      err_q          <= err_d;
      restart_seen_q <= (state_q == StRestart);
    end
  end

  assign err_o = err_q;
`else
  logic unused_abro_state;
  assign unused_abro_state = ^abro_state_i;
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_abro_ctrl.sv
// Directed self-checking bench for abro_ctrl (NumReq=4, Timeout=16).
module tb_abro_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = '0;
  logic [3:0] ev_a_i = '0;
  logic [3:0] ev_b_i = '0;
  logic [3:0] grant_o, done_o, abort_o;
  logic       abro_a_o, abro_b_o, abro_rst_n_o;
  logic       abro_o_i = 1'b0;
  logic [3:0] abro_state_i = 4'b0001;
  logic       err_o;

  int n_checks = 0;
  int n_fail   = 0;

  abro_ctrl #(
    .NumReq (4),
    .Timeout(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .ev_a_i      (ev_a_i),
    .ev_b_i      (ev_b_i),
    .grant_o     (grant_o),
    .done_o      (done_o),
    .abort_o     (abort_o),
    .abro_a_o    (abro_a_o),
    .abro_b_o    (abro_b_o),
    .abro_rst_n_o(abro_rst_n_o),
    .abro_o_i    (abro_o_i),
    .abro_state_i(abro_state_i),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 6 && grant_o == 4'b0000; i++) tick();
  endtask

  logic [3:0] rr_exp [5];
  logic       quiet;

  initial begin
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    // Reset
    repeat (3) tick();
    check_eq("rst_grant", 32'(grant_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_abort", 32'(abort_o), 0);
    check_eq("rst_ab", {30'd0, abro_a_o, abro_b_o}, 0);
    check_eq("rst_abro_rst_n", 32'(abro_rst_n_o), 0);
    check_eq("rst_err", 32'(err_o), 0);
    rst_i = 1'b0;
    tick();
    check_eq("post_rst_abro_rst_n", 32'(abro_rst_n_o), 1);
    check_eq("post_rst_grant", 32'(grant_o), 0);

    // Single transaction; non-owner events must be ignored
    req_i = 4'b0010;
    tick();
    check_eq("single_grant", 32'(grant_o), 32'b0010);
    ev_a_i = 4'b0010;
    ev_b_i = 4'b0001;
    tick();
    check_eq("single_ev_a", {30'd0, abro_a_o, abro_b_o}, 32'b10);
    ev_a_i = 4'b0000;
    ev_b_i = 4'b0010;
    tick();
    check_eq("single_ev_b", {30'd0, abro_a_o, abro_b_o}, 32'b01);
    ev_b_i   = 4'b0000;
    abro_o_i = 1'b1;
    tick();
    check_eq("single_done", 32'(done_o), 32'b0010);
    check_eq("single_restart_rst_n", 32'(abro_rst_n_o), 0);
    check_eq("single_restart_grant", 32'(grant_o), 0);
    check_eq("single_restart_ab", {30'd0, abro_a_o, abro_b_o}, 0);
    abro_o_i = 1'b0;
    req_i    = 4'b0000;
    tick();
    check_eq("single_done_pulse", 32'(done_o), 0);
    check_eq("single_idle_rst_n", 32'(abro_rst_n_o), 1);

    // Round robin from a fresh reset
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant();
      check_eq($sformatf("rr_grant%0d", t), 32'(grant_o), 32'(rr_exp[t]));
      abro_o_i = 1'b1;
      tick();
      abro_o_i = 1'b0;
      check_eq($sformatf("rr_done%0d", t), 32'(done_o), 32'(rr_exp[t]));
    end

    // Reset mid-BUSY with O present: no pulse, rr_ptr back to 0
    wait_grant();
    check_eq("midrst_grant", 32'(grant_o), 32'b0010);
    rst_i    = 1'b1;
    abro_o_i = 1'b1;
    tick();
    check_eq("midrst_done", 32'(done_o), 0);
    check_eq("midrst_grant0", 32'(grant_o), 0);
    check_eq("midrst_rst_n", 32'(abro_rst_n_o), 0);
    rst_i    = 1'b0;
    abro_o_i = 1'b0;
    tick();
    check_eq("midrst_rr_ptr", 32'(grant_o), 32'b0001);

    // Early release
    req_i = 4'b0000;
    tick();
    check_eq("early_pulses", {28'd0, done_o | abort_o}, 0);
    check_eq("early_grant", 32'(grant_o), 0);
    check_eq("early_rst_n", 32'(abro_rst_n_o), 0);
    tick();

    // Timeout: rr_ptr=1 wraps to requester 0
    req_i = 4'b0001;
    tick();
    check_eq("to_grant", 32'(grant_o), 32'b0001);
    quiet = 1'b1;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (done_o != 0 || abort_o != 0 || grant_o != 4'b0001) quiet = 1'b0;
    end
    check_eq("to_quiet_busy", 32'(quiet), 1);
    tick();
    check_eq("to_abort", 32'(abort_o), 32'b0001);
    check_eq("to_no_done", 32'(done_o), 0);
    check_eq("to_rst_n", 32'(abro_rst_n_o), 0);
    req_i = 4'b0000;
    tick();
    check_eq("to_abort_pulse", 32'(abort_o), 0);

    // O on the timeout cycle: done wins
    req_i = 4'b0010;
    tick();
    check_eq("otie_grant", 32'(grant_o), 32'b0010);
    repeat (15) tick();
    abro_o_i = 1'b1;
    tick();
    abro_o_i = 1'b0;
    check_eq("otie_done", 32'(done_o), 32'b0010);
    check_eq("otie_abort", 32'(abort_o), 0);
    req_i = 4'b0000;
    tick();

    // O together with req drop: done still pulsed
    req_i = 4'b0100;
    tick();
    check_eq("odrop_grant", 32'(grant_o), 32'b0100);
    req_i    = 4'b0000;
    abro_o_i = 1'b1;
    tick();
    abro_o_i = 1'b0;
    check_eq("odrop_done", 32'(done_o), 32'b0100);
    tick();

    // State check
    abro_state_i = 4'b0110;
    tick();
    abro_state_i = 4'b0001;
`ifdef ABRO_CTRL_STATE_CHECK_EN
    check_eq("err_set", 32'(err_o), 1);
    repeat (2) tick();
    check_eq("err_sticky", 32'(err_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("err_clear", 32'(err_o), 0);
`else
    check_eq("err_tied", 32'(err_o), 0);
    repeat (2) tick();
    check_eq("err_tied_hold", 32'(err_o), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
